// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, FSM state type and accumulator add helpers for mac_unit
// Contents: DATA_W/ACC_W/PROD_W/CNT_W localparams, state_t, add_res_t,
//           mag() operand magnitude, sat_add() wrapped + saturated add with overflow flag.
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC
  } state_t;

  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] wrap;
    logic [ACC_W-1:0] sat;
  } add_res_t;

  // Unsigned magnitude of a two's complement operand; -128 maps to 128 (8'h80).
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? -x : x;
  endfunction

  // Signed add: overflow when both addends share a sign the sum does not.
  // sat clamps toward the addends' sign on overflow.
  function automatic add_res_t sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    add_res_t r;
    r.wrap = a + b;
    r.ovf  = (a[ACC_W-1] == b[ACC_W-1]) && (r.wrap[ACC_W-1] != a[ACC_W-1]);
    if (r.ovf) begin
      r.sat = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      r.sat = r.wrap;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_seq_mult.sv
// rtl/mac_seq_mult.sv - signed sign-magnitude shift-add multiplier, one operand bit per cycle
// Ports: clk, reset (async active-low), start (load a/b), a, b (signed DATA_W),
//        busy (high while iterations remain beyond the current one),
//        product (signed PROD_W, valid once busy has dropped and the final iteration has run).
module mac_seq_mult
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [PROD_W-1:0] product
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              run_q, run_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q, acc_d;

  always_comb begin
    run_d    = run_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      run_d    = 1'b1;
      neg_d    = a[DATA_W-1] ^ b[DATA_W-1];
      cnt_d    = '0;
      mcand_d  = mag(a);
      mplier_d = mag(b);
      acc_d    = '0;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + (PROD_W'(mcand_q) << cnt_q);
      end
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Drops during the final iteration so the caller can advance on the same
  // edge that completes the product.
  assign busy    = run_q && (cnt_q != LAST);
  assign product = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed 8x8 multiply-accumulate element with sticky overflow flag
// Ports: clk, reset (async active-low), valid (operand strobe, sampled in IDLE only),
//        A, B (signed DATA_W), y (signed ACC_W accumulator), overflow (sticky), done (1-cycle pulse).
// Build option: MAC_SATURATE_EN clamps y on overflow instead of wrapping.
module mac_unit
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [ACC_W-1:0]  y,
  output logic              overflow,
  output logic              done
);

  state_t state_q, state_d;

  logic [ACC_W-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic              mult_start;
  logic              mult_busy;
  logic [PROD_W-1:0] mult_product;
  logic              acc_en;
  logic [ACC_W-1:0]  prod_ext;
  add_res_t          add_res;

  mac_seq_mult u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mult_start),
    .a       (A),
    .b       (B),
    .busy    (mult_busy),
    .product (mult_product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = MUL;
      MUL:     if (!mult_busy) state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mult_start = (state_q == IDLE) && valid;
    acc_en     = (state_q == ACC);
  end

  assign prod_ext = ACC_W'($signed(mult_product));
  assign add_res  = sat_add(y_q, prod_ext);

  always_comb begin
    y_d    = y_q;
    ovf_d  = ovf_q;
    done_d = acc_en;
    if (acc_en) begin
      ovf_d = ovf_q | add_res.ovf;
`ifdef MAC_SATURATE_EN
      y_d   = add_res.sat;
`else
      y_d   = add_res.wrap;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q    <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign y        = y_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mac_unit.sv
// tb/tb_mac_unit.sv - table-driven scoreboard bench for mac_unit
module tb_mac_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [15:0] y;
  logic        overflow;
  logic        done;

  always #5 clk = ~clk;

  mac_unit dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .A        (A),
    .B        (B),
    .y        (y),
    .overflow (overflow),
    .done     (done)
  );

  typedef struct {
    bit rst;
    int a;
    int b;
    int y;
    bit ovf;
  } vec_t;

  typedef struct {
    int y;
    bit ovf;
    int idx;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  function automatic vec_t mk(bit r, int a, int b, int yy, bit o);
    vec_t v;
    v.rst = r;
    v.a   = a;
    v.b   = b;
    v.y   = yy;
    v.ovf = o;
    return v;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && done) begin
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("y[%0d]", e.idx), $signed(y), e.y);
        check($sformatf("overflow[%0d]", e.idx), int'(overflow), int'(e.ovf));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_y", $signed(y), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_done", int'(done), 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_op(int a, int b, int yy, bit o, int idx);
    int   lat;
    exp_t e;
    logic [31:0] av, bv;
    av  = a;
    bv  = b;
    lat = -1;
    @(posedge clk);
    #1;
    valid = 1'b1;
    A     = av[7:0];
    B     = bv[7:0];
    @(posedge clk);
    #1;
    valid = 1'b0;
    e.y   = yy;
    e.ovf = o;
    e.idx = idx;
    sb.push_back(e);
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
    check($sformatf("latency[%0d]", idx), lat, 9);
    if (lat < 0 && sb.size() > 0) void'(sb.pop_back());
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int dc;
    exp_t e;

    tv.push_back(mk(0,   30,   40,   1200, 0));
    tv.push_back(mk(0,   10,    8,   1280, 0));
    tv.push_back(mk(0,   50,   25,   2530, 0));
    tv.push_back(mk(0,  100,   23,   4830, 0));
    tv.push_back(mk(0,  100,   24,   7230, 0));
    tv.push_back(mk(0,  100,   -2,   7030, 0));
    tv.push_back(mk(0,   11,  -11,   6909, 0));
    tv.push_back(mk(0,    7,    2,   6923, 0));
    tv.push_back(mk(0,   40,  -50,   4923, 0));
    tv.push_back(mk(0, -111,   -2,   5145, 0));
    tv.push_back(mk(0, -127,  127, -10984, 0));
    tv.push_back(mk(0, -127,  127, -27113, 0));
`ifdef MAC_SATURATE_EN
    tv.push_back(mk(0, -127,  127, -32768, 1));
`else
    tv.push_back(mk(0, -127,  127,  22294, 1));
`endif
    tv.push_back(mk(1,  105,   49,   5145, 0));
    tv.push_back(mk(0,  127,  127,  21274, 0));
`ifdef MAC_SATURATE_EN
    tv.push_back(mk(0,  127,  127,  32767, 1));
    tv.push_back(mk(0,    1,    1,  32767, 1));
`else
    tv.push_back(mk(0,  127,  127, -28133, 1));
    tv.push_back(mk(0,    1,    1, -28132, 1));
`endif
    tv.push_back(mk(1, -128, -128,  16384, 0));
    tv.push_back(mk(0, -128,  127,    128, 0));

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("init_y", $signed(y), 0);
    check("init_overflow", int'(overflow), 0);
    check("init_done", int'(done), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_y", $signed(y), 0);
    check("idle_done_count", done_count, 0);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      run_op(tv[i].a, tv[i].b, tv[i].y, tv[i].ovf, i);
    end

    // valid while busy must be dropped, not queued
    do_reset();
    dc = done_count;
    @(posedge clk);
    #1;
    valid = 1'b1;
    A = 8'd3;
    B = 8'd4;
    @(posedge clk);
    #1;
    valid = 1'b0;
    e.y   = 12;
    e.ovf = 1'b0;
    e.idx = 100;
    sb.push_back(e);
    repeat (2) @(posedge clk);
    #1;
    valid = 1'b1;
    A = 8'd5;
    B = 8'd5;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (25) @(negedge clk);
    check("busy_done_count", done_count - dc, 1);
    check("busy_y", $signed(y), 12);
    check("busy_sb_empty", sb.size(), 0);

    // reset in the middle of a multiply aborts it
    dc = done_count;
    @(posedge clk);
    #1;
    valid = 1'b1;
    A = 8'd7;
    B = 8'd7;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_y", $signed(y), 0);
    check("abort_done", int'(done), 0);
    check("abort_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_done_count", done_count - dc, 0);
    check("abort_y_after", $signed(y), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
